// File: rtl/adc733_pkg.sv
// Shared definitions for the adc733 codec emulator: word layout, register
// file size and the control-word decoder used by the receive path.
package adc733_pkg;

  localparam int WORD_W   = 16;
  localparam int NUM_CR   = 8;
  localparam int MODE_BIT = 15;
  localparam int CTRL_BIT = 14;
  localparam int ADDR_HI  = 10;
  localparam int ADDR_LO  = 8;
  localparam int DATA_HI  = 7;
  localparam int DATA_LO  = 0;

  typedef enum logic [0:0] {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

  typedef struct packed {
    logic       wr;        // word addresses the control register file
    logic       mode_req;  // word requests the switch to data mode
    logic [2:0] addr;
    logic [7:0] data;
  } ctrl_dec_t;

  // Split a received word into its control-register write fields.
  function automatic ctrl_dec_t decode_ctrl(input logic [WORD_W-1:0] w);
    ctrl_dec_t d;
    d.wr       = w[CTRL_BIT];
    d.mode_req = w[CTRL_BIT] & w[MODE_BIT];
    d.addr     = w[ADDR_HI:ADDR_LO];
    d.data     = w[DATA_HI:DATA_LO];
    return d;
  endfunction

endpackage

// File: rtl/adc733_codec_emu_if.sv
// Serial port between the codec emulator (master: owns SCLK and the
// output frame) and the DSP-side wrapper (slave: drives the input frame).
interface adc733_codec_emu_if;
  logic sclk;
  logic sdofs;
  logic sdo;
  logic sdifs;
  logic sdi;

  modport master (output sclk, output sdofs, output sdo, input sdifs, input sdi);
  modport slave  (input sclk, input sdofs, input sdo, output sdifs, output sdi);
endinterface

// File: rtl/adc733_sclk_gen.sv
// SCLK divider: toggles sclk every SCLK_DIV clk cycles and flags the clk
// cycle on which the register flips 0->1 (rise) or 1->0 (fall).
module adc733_sclk_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic [CW-1:0] div_cnt_r;
  logic          sclk_r;
  logic          tick_s;

  assign tick_s = (div_cnt_r == CW'(SCLK_DIV - 1));
  assign rise   = tick_s & ~sclk_r;
  assign fall   = tick_s & sclk_r;
  assign sclk   = sclk_r;

  // Half-period counter and serial clock register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= {CW{1'b0}};
      sclk_r    <= 1'b0;
    end else if (tick_s) begin
      div_cnt_r <= {CW{1'b0}};
      sclk_r    <= ~sclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + CW'(1'b1);
    end
  end

endmodule

// File: rtl/adc733_codec_emu.sv
// Codec-side emulator of the adc733 serial port. Generates SCLK, sends
// 16-bit frames on SDOFS/SDO (echo in program mode, samples in data mode)
// and deserializes control words from SDIFS/SDI into an 8x8 register file.
module adc733_codec_emu
  import adc733_pkg::*;
#(
  parameter int SCLK_DIV    = 2,
  parameter int FRAME_SCLKS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                se,
  adc733_codec_emu_if.master  ser,
  input  logic [WORD_W-1:0]   sample_i,
  output logic                sample_rd,
  output logic [WORD_W-1:0]   rx_word,
  output logic                rx_valid,
  output logic [NUM_CR*8-1:0] cr_flat,
  output logic                data_mode,
  output logic                frame_err
);

  localparam int FCW = $clog2(FRAME_SCLKS);

  logic rise_s;
  logic fall_s;

  adc733_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .clk  (clk),
    .rst  (rst),
    .sclk (ser.sclk),
    .rise (rise_s),
    .fall (fall_s)
  );

  // ---------------- receive path ----------------
  rx_state_e                rx_state_r, rx_state_nxt_s;
  logic [WORD_W-1:0]        rx_shift_r, rx_shift_nxt_s, rx_word_s;
  logic [3:0]               rx_cnt_r, rx_cnt_nxt_s;
  logic                     rx_done_s, rx_err_s;
  ctrl_dec_t                dec_s;
  logic [NUM_CR-1:0][7:0]   cr_r;
  logic [WORD_W-1:0]        echo_r, rx_word_r;
  logic                     rx_valid_r, frame_err_r, mode_req_r;

  assign rx_word_s = {rx_shift_r[WORD_W-2:0], ser.sdi};
  assign dec_s     = decode_ctrl(rx_word_s);

  // Receive FSM next state: bits are taken on rise events only; a frame
  // sync while shifting abandons the partial word and restarts at bit 15.
  always_comb begin
    rx_state_nxt_s = rx_state_r;
    rx_shift_nxt_s = rx_shift_r;
    rx_cnt_nxt_s   = rx_cnt_r;
    rx_done_s      = 1'b0;
    rx_err_s       = 1'b0;
    if (rise_s) begin
      case (rx_state_r)
        RX_IDLE: begin
          if (ser.sdifs) begin
            rx_state_nxt_s = RX_SHIFT;
            rx_shift_nxt_s = {{(WORD_W-1){1'b0}}, ser.sdi};
            rx_cnt_nxt_s   = 4'd1;
          end else begin
            rx_state_nxt_s = RX_IDLE;
          end
        end
        RX_SHIFT: begin
          if (ser.sdifs) begin
            rx_err_s       = 1'b1;
            rx_shift_nxt_s = {{(WORD_W-1){1'b0}}, ser.sdi};
            rx_cnt_nxt_s   = 4'd1;
          end else if (rx_cnt_r == 4'd15) begin
            rx_done_s      = 1'b1;
            rx_state_nxt_s = RX_IDLE;
            rx_shift_nxt_s = rx_word_s;
            rx_cnt_nxt_s   = 4'd0;
          end else begin
            rx_shift_nxt_s = rx_word_s;
            rx_cnt_nxt_s   = rx_cnt_r + 4'd1;
          end
        end
        default: begin
          rx_state_nxt_s = RX_IDLE;
        end
      endcase
    end else begin
      rx_state_nxt_s = rx_state_r;
    end
  end

  // Receive state, completed-word capture and control register writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r  <= RX_IDLE;
      rx_shift_r  <= {WORD_W{1'b0}};
      rx_cnt_r    <= 4'd0;
      rx_word_r   <= {WORD_W{1'b0}};
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      cr_r        <= {(NUM_CR*8){1'b0}};
      echo_r      <= {WORD_W{1'b0}};
      mode_req_r  <= 1'b0;
    end else begin
      rx_state_r  <= rx_state_nxt_s;
      rx_shift_r  <= rx_shift_nxt_s;
      rx_cnt_r    <= rx_cnt_nxt_s;
      rx_valid_r  <= rx_done_s;
      frame_err_r <= rx_err_s;
      if (rx_done_s) begin
        rx_word_r <= rx_word_s;
        if (dec_s.wr) begin
          cr_r[dec_s.addr] <= dec_s.data;
          echo_r           <= rx_word_s;
        end
        if (dec_s.mode_req) begin
          mode_req_r <= 1'b1;
        end
      end
    end
  end

  // ---------------- transmit path ----------------
  logic [FCW-1:0]    fcnt_r, fcnt_nxt_s;
  logic [WORD_W-1:0] tx_shift_r, tx_shift_nxt_s;
  logic              tx_act_r, tx_act_nxt_s;
  logic              sdofs_r, sdofs_nxt_s, sdo_r, sdo_nxt_s;
  logic              data_mode_r, data_mode_nxt_s;
  logic              sample_rd_s, sample_rd_r;

  // Frame sequencing on fall events: start (latch word, raise sync),
  // shift out bits 14..0, then idle low for the rest of the frame.
  always_comb begin
    fcnt_nxt_s      = fcnt_r;
    tx_shift_nxt_s  = tx_shift_r;
    tx_act_nxt_s    = tx_act_r;
    sdofs_nxt_s     = sdofs_r;
    sdo_nxt_s       = sdo_r;
    data_mode_nxt_s = data_mode_r;
    sample_rd_s     = 1'b0;
    if (fall_s) begin
      if (fcnt_r == FCW'(FRAME_SCLKS - 1)) begin
        fcnt_nxt_s = {FCW{1'b0}};
      end else begin
        fcnt_nxt_s = fcnt_r + FCW'(1'b1);
      end
      if (fcnt_r == {FCW{1'b0}}) begin
        if (se) begin
          data_mode_nxt_s = data_mode_r | mode_req_r;
          tx_shift_nxt_s  = data_mode_nxt_s ? sample_i : echo_r;
          sample_rd_s     = data_mode_nxt_s;
          tx_act_nxt_s    = 1'b1;
          sdofs_nxt_s     = 1'b1;
          sdo_nxt_s       = tx_shift_nxt_s[WORD_W-1];
        end else begin
          tx_act_nxt_s = 1'b0;
          sdofs_nxt_s  = 1'b0;
          sdo_nxt_s    = 1'b0;
        end
      end else if (fcnt_r < FCW'(WORD_W)) begin
        tx_act_nxt_s   = tx_act_r & se;
        sdofs_nxt_s    = 1'b0;
        sdo_nxt_s      = tx_act_r & se & tx_shift_r[WORD_W-2];
        tx_shift_nxt_s = {tx_shift_r[WORD_W-2:0], 1'b0};
      end else begin
        tx_act_nxt_s = 1'b0;
        sdofs_nxt_s  = 1'b0;
        sdo_nxt_s    = 1'b0;
      end
    end else begin
      fcnt_nxt_s = fcnt_r;
    end
  end

  // Transmit registers; all serial outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_r      <= {FCW{1'b0}};
      tx_shift_r  <= {WORD_W{1'b0}};
      tx_act_r    <= 1'b0;
      sdofs_r     <= 1'b0;
      sdo_r       <= 1'b0;
      data_mode_r <= 1'b0;
      sample_rd_r <= 1'b0;
    end else begin
      fcnt_r      <= fcnt_nxt_s;
      tx_shift_r  <= tx_shift_nxt_s;
      tx_act_r    <= tx_act_nxt_s;
      sdofs_r     <= sdofs_nxt_s;
      sdo_r       <= sdo_nxt_s;
      data_mode_r <= data_mode_nxt_s;
      sample_rd_r <= sample_rd_s;
    end
  end

  assign ser.sdofs = sdofs_r;
  assign ser.sdo   = sdo_r;
  assign sample_rd = sample_rd_r;
  assign rx_word   = rx_word_r;
  assign rx_valid  = rx_valid_r;
  assign cr_flat   = cr_r;
  assign data_mode = data_mode_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_adc733_codec_emu.sv
// Self-checking bench for adc733_codec_emu: acts as the DSP side, sending
// control words and capturing output frames, with a register-file/echo
// model and a record of presented samples as the reference.
module tb_adc733_codec_emu;
  import adc733_pkg::*;

  localparam int SCLK_DIV    = 2;
  localparam int FRAME_SCLKS = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        se;
  logic [15:0] sample_i;
  logic        sample_rd;
  logic [15:0] rx_word;
  logic        rx_valid;
  logic [63:0] cr_flat;
  logic        data_mode;
  logic        frame_err;

  adc733_codec_emu_if sp();

  adc733_codec_emu #(.SCLK_DIV(SCLK_DIV), .FRAME_SCLKS(FRAME_SCLKS)) dut (
    .clk(clk), .rst(rst), .se(se), .ser(sp), .sample_i(sample_i),
    .sample_rd(sample_rd), .rx_word(rx_word), .rx_valid(rx_valid),
    .cr_flat(cr_flat), .data_mode(data_mode), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------- reference model: register file and echo ----------
  logic [7:0]  cr_m [8];
  logic [15:0] echo_m;

  task automatic model_word(input logic [15:0] w);
    if (w[14]) begin
      cr_m[w[10:8]] = w[7:0];
      echo_m = w;
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    f = 64'd0;
    for (int i = 0; i < 8; i++) f = f | ({56'd0, cr_m[i]} << (8 * i));
    return f;
  endfunction

  // ---------- monitors ----------
  int          cyc = 0;
  int          n_valid = 0, n_ferr = 0, n_rd = 0;
  logic [15:0] last_sample;
  bit          first_rd_done = 1'b0;
  logic        prev_dm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    if (rx_valid === 1'b1) begin
      n_valid++;
      check("rx_valid_with_sclk_high", sp.sclk, 1'b1);
    end
    if (frame_err === 1'b1) n_ferr++;
    if (sample_rd === 1'b1) begin
      n_rd++;
      check("sample_rd_in_data_mode", data_mode, 1'b1);
      if (!first_rd_done) begin
        first_rd_done = 1'b1;
        check("data_mode_rises_with_first_rd", {prev_dm, data_mode}, 2'b01);
      end
      last_sample = sample_i;
      sample_i = 16'($urandom);
    end
    prev_dm = data_mode;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------- DSP-side serial drivers ----------
  task automatic drive_bit(input logic fs, input logic b);
    @(negedge sp.sclk);
    @(negedge clk);
    sp.sdifs = fs;
    sp.sdi   = b;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) drive_bit(i == 15, w[i]);
    drive_bit(1'b0, 1'b0);
  endtask

  task automatic capture_frame(output logic [15:0] w);
    int  guard;
    bit  found;
    guard = 0;
    found = 1'b0;
    w = 16'd0;
    while (!found && guard < 3 * FRAME_SCLKS) begin
      @(posedge sp.sclk); #1;
      guard++;
      if (sp.sdofs === 1'b1) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_timeout: got no sdofs expected a frame");
    end else begin
      w[15] = sp.sdo;
      for (int i = 14; i >= 0; i--) begin
        @(posedge sp.sclk); #1;
        w[i] = sp.sdo;
      end
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [63:0] exp_cr;
    logic [15:0] exp_echo;
  } vec_t;

  vec_t        tbl [5];
  logic [15:0] w, fw;
  int          c1, c2, v0, f0, r0, acc;

  initial begin
    tbl[0] = '{16'h4201, 64'h0000_0000_0001_0000, 16'h4201};
    tbl[1] = '{16'h0255, 64'h0000_0000_0001_0000, 16'h4201};
    tbl[2] = '{16'h45AB, 64'h0000_AB00_0001_0000, 16'h45AB};
    tbl[3] = '{16'h47FF, 64'hFF00_AB00_0001_0000, 16'h47FF};
    tbl[4] = '{16'h4200, 64'hFF00_AB00_0000_0000, 16'h4200};
    for (int i = 0; i < 8; i++) cr_m[i] = 8'h00;
    echo_m = 16'h0000;

    rst = 1'b1; se = 1'b1; sp.sdifs = 1'b0; sp.sdi = 1'b0;
    sample_i = 16'($urandom);

    // reset and SCLK / first frame
    repeat (5) @(posedge clk);
    #1;
    check("reset_outputs", {sp.sclk, sp.sdofs, sp.sdo, sample_rd, rx_valid, frame_err, data_mode}, 7'd0);
    check("reset_regs", {rx_word, cr_flat}, 80'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge sp.sclk); #1; c1 = cyc;
    @(negedge sp.sclk); #1;
    check("first_frame_on_first_fall", sp.sdofs, 1'b1);
    @(posedge sp.sclk); #1; c2 = cyc;
    check("sclk_period", c2 - c1, 2 * SCLK_DIV);
    @(negedge sp.sclk); #1;
    check("sdofs_one_sclk_wide", sp.sdofs, 1'b0);
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge sp.sclk); #1;
      if (sp.sdo === 1'b1) acc++;
    end
    check("first_frame_sdo_zero", acc, 0);

    // table-driven program-mode words
    for (int i = 0; i < 5; i++) begin
      v0 = n_valid;
      send_word(tbl[i].word);
      model_word(tbl[i].word);
      check("tbl_rx_valid_once", n_valid - v0, 1);
      check("tbl_rx_word", rx_word, tbl[i].word);
      check("tbl_cr_flat", cr_flat, tbl[i].exp_cr);
      capture_frame(fw);
      check("tbl_echo_frame", fw, tbl[i].exp_echo);
    end

    // randomized program-mode words against the model
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom);
      w[15] = 1'b0;
      send_word(w);
      model_word(w);
      check("rnd_rx_word", rx_word, w);
      check("rnd_cr_flat", cr_flat, model_flat());
      capture_frame(fw);
      check("rnd_echo_frame", fw, echo_m);
    end
    check("no_frame_err_yet", n_ferr, 0);
    check("program_mode_no_rd", {data_mode, 32'(n_rd)}, 33'd0);

    // switch to data mode
    r0 = n_rd;
    send_word(16'hC008);
    model_word(16'hC008);
    check("mode_word_cr0", cr_flat, model_flat());
    for (int i = 0; i < 3; i++) begin
      capture_frame(fw);
      check("data_frame_sample", fw, last_sample);
      check("one_rd_per_frame", n_rd - r0, 1);
      r0 = n_rd;
    end
    send_word(16'h4000);
    model_word(16'h4000);
    check("ctrl_word_keeps_data_mode", data_mode, 1'b1);
    check("ctrl_word_cr0_cleared", cr_flat, model_flat());
    capture_frame(fw);
    check("still_data_frame", fw, last_sample);

    // framing error: 7 bits, then a full 0x4377
    v0 = n_valid; f0 = n_ferr;
    drive_bit(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) drive_bit(1'b0, 1'($urandom));
    send_word(16'h4377);
    model_word(16'h4377);
    check("frame_err_once", n_ferr - f0, 1);
    check("err_rx_valid_once", n_valid - v0, 1);
    check("err_rx_word", rx_word, 16'h4377);
    check("err_cr3", cr_flat, model_flat());

    // se gating for two frame periods
    capture_frame(fw);
    @(negedge clk) se = 1'b0;
    r0 = n_rd; acc = 0;
    for (int i = 0; i < 2 * FRAME_SCLKS; i++) begin
      @(posedge sp.sclk); #1;
      if (sp.sdofs === 1'b1 || sp.sdo === 1'b1) acc++;
    end
    check("se_low_no_frames", acc, 0);
    check("se_low_no_rd", n_rd - r0, 0);
    @(negedge clk) se = 1'b1;
    capture_frame(fw);
    check("se_resume_frame", fw, last_sample);
    check("se_resume_rd", n_rd - r0, 1);

    // reset in the middle of a frame and of a received word
    @(negedge clk) sample_i = 16'hFFFF;
    acc = 0;
    while (sp.sdofs !== 1'b1 && acc < 4 * FRAME_SCLKS * SCLK_DIV) begin
      @(posedge clk); #1;
      acc++;
    end
    w = 16'h4FFF;
    for (int i = 15; i >= 11; i--) drive_bit(i == 15, w[i]);
    check("pre_reset_sdo_high", {sp.sdo, data_mode}, 2'b11);
    v0 = n_valid;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_outputs", {sp.sclk, sp.sdofs, sp.sdo, sample_rd, rx_valid, data_mode}, 6'd0);
    check("mid_reset_regs", {rx_word, cr_flat}, 80'd0);
    @(negedge clk) rst = 1'b0;
    r0 = n_rd;
    for (int i = 10; i >= 0; i--) drive_bit(1'b0, w[i]);
    drive_bit(1'b0, 1'b0);
    check("partial_word_dropped", {32'(n_valid - v0), cr_flat}, 96'd0);
    capture_frame(fw);
    check("post_reset_echo_zero", fw, 16'h0000);
    check("post_reset_program_mode", {data_mode, 32'(n_rd - r0)}, 33'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
